bram_dump_reader: RTL

Hardware readback engine for the shared BRAM port of pipelined_processor, the read-side counterpart of the program loader.
- On start: holds the core in reset, reads a contiguous range of words through shared_bram_addr/bram_dout, and streams them out on a valid/ready interface.
- Used to dump results (e.g. matrix-multiply output) after a run completes.

---
 rtl/bram_dump_reader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bram_dump_reader.sv
// Readback engine: holds the core in reset and streams a contiguous BRAM range out on valid/ready.
// Optional running checksum of delivered beats when DUMP_CHECKSUM_EN is defined.
module bram_dump_reader #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SIZE    = 128,
  parameter int unsigned NUM_COL = 4,
  localparam int unsigned LOGSIZE = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LOGSIZE+2:0]   base_addr,
  input  logic [LOGSIZE+1:0]   word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 core_hold,
  output logic [LOGSIZE+2:0]   shared_bram_addr,
  output logic [NUM_COL-1:0]   bram_wr_en,
  output logic [WIDTH-1:0]     bram_din,
  input  logic [WIDTH-1:0]     bram_dout,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
`ifdef DUMP_CHECKSUM_EN
  output logic                 m_last,
  output logic [WIDTH-1:0]     checksum
`else
  output logic                 m_last
`endif
);

  localparam int unsigned AW = LOGSIZE + 3;
  localparam int unsigned CW = LOGSIZE + 2;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   issued_q;
  logic [CW-1:0]   beats_q;
  logic [CW-1:0]   beats_next;
  logic [CW-1:0]   last_idx;
  logic            busy_q;
  logic            done_q;
  logic            inflight_q;

  logic [WIDTH-1:0] fifo_mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       fifo_cnt_q;

  logic       pop;
  logic       issue;
  logic [2:0] occ;
  logic       unused_base;

  assign unused_base = ^base_addr[1:0];

  assign bram_wr_en       = '0;
  assign bram_din         = '0;
  assign busy             = busy_q;
  assign core_hold        = busy_q;
  assign done             = done_q;
  assign shared_bram_addr = addr_q;

  assign m_valid = (fifo_cnt_q != 2'd0);
  assign m_data  = fifo_mem_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  assign beats_next = beats_q + CW'(pop);
  assign last_idx   = count_q - CW'(1);
  assign m_last     = m_valid & (beats_q == last_idx);

  // Buffered plus in-flight words, net of this cycle's pop, must leave room for one more capture.
  assign occ   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == StRead) && (issued_q != count_q) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (pop) beats_q <= beats_next;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q   <= {base_addr[AW-1:2], 2'b00};
            count_q  <= word_count;
            issued_q <= '0;
            beats_q  <= '0;
            busy_q   <= 1'b1;
            // An empty dump passes through DRAIN, which finishes at once with zero beats.
            state_q  <= (word_count == '0) ? StDrain : StRead;
          end
        end
        StRead: begin
          if (issue) begin
            addr_q   <= addr_q + AW'(4);
            issued_q <= issued_q + CW'(1);
          end
          if (issued_q == count_q) state_q <= StDrain;
        end
        StDrain: begin
          if (beats_next == count_q) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-entry skid FIFO; a read issued last cycle lands here now.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_mem_q[wr_ptr_q] <= bram_dout;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({inflight_q, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q;

  assign checksum = checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + m_data;
    end
  end
`endif

endmodule
